// File: rtl/tt_um_micro_tdc.sv
// Micro time-to-digital converter: start/stop interval counter with status readout.
// Optional 4-shot averaging is enabled by defining MICRO_TDC_AVG_EN.
module tt_um_micro_tdc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state, state_d;
  logic [3:0]  raw, sync1, sync2, prev, pulse;
  logic        start_p, stop_p, arm_p, abort_p;
  logic [15:0] cnt, cnt_d, cnt_inc;
  logic [15:0] res, res_d, meas_val;
  logic        valid, valid_d;
  logic        ovf, ovf_d;
  logic        meas_end;
  logic [3:0]  meas, meas_d;
  logic [1:0]  unused_bits;

`ifdef MICRO_TDC_AVG_EN
  logic [17:0] acc, acc_d, acc_sum;
  logic [1:0]  sub, sub_d;
  assign acc_sum = acc + {2'b00, meas_val};
`endif

  assign unused_bits = ui_in[7:6];
  assign raw = {ui_in[5], ui_in[2], ui_in[1], ui_in[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Identical sync+edge depth on every input keeps start/stop latency-matched.
  assign pulse   = sync2 & ~prev;
  assign start_p = pulse[0];
  assign stop_p  = pulse[1];
  assign arm_p   = pulse[2];
  assign abort_p = pulse[3];
  assign cnt_inc = cnt + 16'd1;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    res_d    = res;
    valid_d  = valid;
    ovf_d    = ovf;
    meas_d   = meas;
    meas_end = 1'b0;
    meas_val = '0;
`ifdef MICRO_TDC_AVG_EN
    acc_d    = acc;
    sub_d    = sub;
`endif
    if (abort_p) begin
      state_d = IDLE;
      cnt_d   = '0;
      res_d   = '0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
      meas_d  = '0;
`ifdef MICRO_TDC_AVG_EN
      acc_d   = '0;
      sub_d   = '0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (arm_p) begin
            state_d = ARMED;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
`ifdef MICRO_TDC_AVG_EN
            acc_d   = '0;
            sub_d   = '0;
`endif
          end
        end
        ARMED: begin
          if (start_p) begin
            cnt_d = '0;
            if (stop_p) meas_end = 1'b1;
            else        state_d  = RUN;
          end
        end
        RUN: begin
          cnt_d = cnt_inc;
          if (cnt_inc == 16'hFFFF) begin
            state_d = DONE;
            res_d   = 16'hFFFF;
            ovf_d   = 1'b1;
            valid_d = 1'b1;
            meas_d  = meas + 4'd1;
          end else if (stop_p) begin
            meas_end = 1'b1;
            meas_val = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (meas_end) begin
`ifdef MICRO_TDC_AVG_EN
      if (sub == 2'd3) begin
        state_d = DONE;
        res_d   = acc_sum[17:2];
        valid_d = 1'b1;
        meas_d  = meas + 4'd1;
        acc_d   = acc_sum;
        sub_d   = '0;
      end else begin
        state_d = ARMED;
        acc_d   = acc_sum;
        sub_d   = sub + 2'd1;
      end
`else
      state_d = DONE;
      res_d   = meas_val;
      valid_d = 1'b1;
      meas_d  = meas + 4'd1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      res   <= '0;
      valid <= 1'b0;
      ovf   <= 1'b0;
      meas  <= '0;
`ifdef MICRO_TDC_AVG_EN
      acc   <= '0;
      sub   <= '0;
`endif
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      res   <= res_d;
      valid <= valid_d;
      ovf   <= ovf_d;
      meas  <= meas_d;
`ifdef MICRO_TDC_AVG_EN
      acc   <= acc_d;
      sub   <= sub_d;
`endif
    end
  end

  always_comb begin
    uo_out = '0;
    unique case (ui_in[4:3])
      2'b00: uo_out = res[7:0];
      2'b01: uo_out = res[15:8];
      2'b10: uo_out = {2'(state), ovf, valid, meas};
      2'b11: uo_out = cnt[7:0];
      default: uo_out = '0;
    endcase
  end

endmodule

// File: tb/tb_tt_um_micro_tdc.sv
// Bench for tt_um_micro_tdc: directed and random start/stop intervals
// checked against an interval/average model built from edge spacing.
module tb_tt_um_micro_tdc;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  int n_cmp;
  int n_err;
  int meas_m;
  int sum_m;
  int shots_m;
  logic [7:0] v;

`ifdef MICRO_TDC_AVG_EN
  localparam int K = 4;
`else
  localparam int K = 1;
`endif

  tt_um_micro_tdc dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ui_in  (ui_in),
    .uo_out (uo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] s, output logic [7:0] o);
    ui_in[4:3] = s;
    #1;
    o = uo_out;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_sel(input string tag, input logic [1:0] s,
                         input logic [7:0] exp);
    logic [7:0] o;
    rd(s, o);
    chk(tag, o, exp);
  endtask

  task automatic shot_begin();
    ui_in[2] = 1'b1;
    tick(4);
    ui_in[2] = 1'b0;
    tick(2);
    sum_m   = 0;
    shots_m = 0;
  endtask

  // Start rises at one sampled edge, stop exactly n edges later.
  task automatic pair(input int n);
    ui_in[0] = 1'b1;
    tick(n);
    ui_in[1] = 1'b1;
    tick(2);
    ui_in[0] = 1'b0;
    ui_in[1] = 1'b0;
    sum_m   += n;
    shots_m++;
    tick(6);
  endtask

  task automatic wait_state(input string tag, input logic [1:0] st,
                            input int limit);
    logic [7:0] o;
    o = '0;
    for (int i = 0; i < limit; i++) begin
      rd(2'b10, o);
      if (o[7:6] == st) break;
      tick(1);
    end
    chk(tag, {6'b0, o[7:6]}, {6'b0, st});
  endtask

  task automatic shot_check(input string tag);
    int exp_res;
    exp_res = (K == 4) ? (sum_m >> 2) : sum_m;
    meas_m  = (meas_m + 1) % 16;
    wait_state({tag, "_state"}, 2'b11, 20);
    chk_sel({tag, "_status"}, 2'b10, {2'b11, 1'b0, 1'b1, 4'(meas_m)});
    chk_sel({tag, "_lo"}, 2'b00, exp_res[7:0]);
    chk_sel({tag, "_hi"}, 2'b01, exp_res[15:8]);
  endtask

  task automatic do_abort();
    ui_in[5] = 1'b1;
    tick(4);
    ui_in[5] = 1'b0;
    tick(2);
    meas_m = 0;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    meas_m = 0;
    ui_in  = '0;
    rst_n  = 1'b0;
    tick(3);
    for (int s = 0; s < 4; s++)
      chk_sel($sformatf("rst_sel%0d", s), 2'(s), 8'h00);
    rst_n = 1'b1;
    tick(2);
    for (int s = 0; s < 4; s++)
      chk_sel($sformatf("post_rst_sel%0d", s), 2'(s), 8'h00);

    // Directed interval: 37 single-shot, or the 10/11/12/14 average
    shot_begin();
`ifdef MICRO_TDC_AVG_EN
    pair(10);
    pair(11);
    pair(12);
    pair(14);
`else
    pair(37);
`endif
    shot_check("directed");

    // Random intervals; 17 shots also wrap the 4-bit measurement count
    for (int i = 0; i < 17; i++) begin
      shot_begin();
      for (int j = 0; j < K; j++) pair(int'($urandom_range(1, 150)));
      ui_in[7:6] = 2'($urandom);
      shot_check($sformatf("rand%0d", i));
    end
    ui_in[7:6] = 2'b00;

    // Saturation with stop never arriving
    do_abort();
    shot_begin();
    ui_in[0] = 1'b1;
    wait_state("sat_state", 2'b11, 65600);
    ui_in[0] = 1'b0;
    meas_m   = (meas_m + 1) % 16;
    chk_sel("sat_status", 2'b10, {2'b11, 1'b1, 1'b1, 4'(meas_m)});
    chk_sel("sat_lo", 2'b00, 8'hFF);
    chk_sel("sat_hi", 2'b01, 8'hFF);

    // Start and stop rising in the same cycle
    shot_begin();
    ui_in[0] = 1'b1;
    ui_in[1] = 1'b1;
    tick(6);
    ui_in[0] = 1'b0;
    ui_in[1] = 1'b0;
`ifdef MICRO_TDC_AVG_EN
    chk_sel("same_status", 2'b10, {2'b01, 1'b0, 1'b0, 4'(meas_m)});
`else
    meas_m = (meas_m + 1) % 16;
    chk_sel("same_status", 2'b10, {2'b11, 1'b0, 1'b1, 4'(meas_m)});
    chk_sel("same_lo", 2'b00, 8'h00);
    chk_sel("same_hi", 2'b01, 8'h00);
`endif
    do_abort();
    chk_sel("abort1_status", 2'b10, 8'h00);

    // Stop before start is ignored, then start runs, then abort
    shot_begin();
    ui_in[1] = 1'b1;
    tick(6);
    chk_sel("stopfirst_status", 2'b10, {2'b01, 1'b0, 1'b0, 4'(meas_m)});
    ui_in[1] = 1'b0;
    ui_in[0] = 1'b1;
    tick(5);
    chk_sel("run_status", 2'b10, {2'b10, 1'b0, 1'b0, 4'(meas_m)});
    tick(5);
    do_abort();
    ui_in[0] = 1'b0;
    chk_sel("abort_status", 2'b10, 8'h00);
    chk_sel("abort_lo", 2'b00, 8'h00);
    chk_sel("abort_hi", 2'b01, 8'h00);
    chk_sel("abort_live", 2'b11, 8'h00);

    // Reset pulsed mid-RUN discards everything
    shot_begin();
    ui_in[0] = 1'b1;
    tick(10);
    rst_n = 1'b0;
    tick(1);
    chk_sel("rst_run_status", 2'b10, 8'h00);
    ui_in[0] = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    meas_m = 0;
    for (int s = 0; s < 4; s++)
      chk_sel($sformatf("rst_run_sel%0d", s), 2'(s), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tt_um_micro_tdc.md
TT_UM_MICRO_TDC -- requirements
Module: tt_um_micro_tdc

Interface
REQ-001 SHALL expose: clk  input  1  single clock; gated low by the container when this tile is not selected.
REQ-002 SHALL expose: rst_n  input  1  asynchronous, active-low reset; held low by the container when this tile is not selected.
REQ-003 SHALL expose: ui_in  input  8  [0]=start, [1]=stop, [2]=arm, [4:3]=readout select, [5]=abort, [7:6]=unused.
REQ-004 SHALL expose: uo_out  output  8  readout byte selected by ui_in[4:3].
REQ-005 SHALL have one clock (clk); reset is asynchronous and active-low (rst_n).

Function
REQ-006 SHALL pass start, stop, arm and abort through 2-flop synchronizers, then a rising-edge detector (1-cycle pulse); all further logic uses the pulses only.
REQ-007 SHALL implement FSM IDLE=0, ARMED=1, RUN=2, DONE=3.
REQ-008 IDLE/DONE: arm pulse -> ARMED; DONE clears valid and ovf on this transition.
REQ-009 ARMED: start pulse -> RUN and clear the 16-bit counter; stop pulse alone is ignored.
REQ-010 RUN: counter increments once per cycle; stop pulse -> DONE, latching result and setting valid; start pulse in RUN is ignored.
REQ-011 Result SHALL equal N when start's rising edge is sampled at clock edge k and stop's at edge k+N (N>=1), i.e. end-to-end latency-matched paths.
REQ-012 Start and stop pulses in the same cycle in ARMED SHALL go to DONE with result 0x0000, valid=1.
REQ-013 Counter SHALL saturate: reaching 0xFFFF in RUN -> DONE, result=0xFFFF, ovf=1, valid=1.
REQ-014 Abort pulse in any state SHALL -> IDLE, clearing counter, result, valid, ovf; abort has priority over all other pulses.
REQ-015 Arm pulse in ARMED or RUN SHALL be ignored.
REQ-016 A 4-bit measurement counter SHALL increment (mod 16) on every entry to DONE; cleared only by reset and abort.
REQ-017 uo_out SHALL be combinational on the select and registered state: 00=result[7:0], 01=result[15:8], 10=status {state[1:0], ovf, valid, meas_cnt[3:0]}, 11=live counter[7:0].
REQ-018 ui_in[7:6] SHALL have no effect.

Reset
REQ-019 rst_n low SHALL asynchronously force: state IDLE, all synchronizer/edge flops 0, counter, result, accumulator 0, valid=0, ovf=0, meas_cnt=0.
REQ-020 uo_out SHALL read 0x00 for every select value while in reset and immediately after it.
REQ-021 Reset asserted mid-RUN SHALL discard the measurement; no partial result is retained.

Configuration
REQ-022 Macro MICRO_TDC_AVG_EN SHALL select averaging.
REQ-023 Without MICRO_TDC_AVG_EN: single-shot behaviour as in REQ-007..REQ-016.
REQ-024 With MICRO_TDC_AVG_EN: each stop in RUN adds the count to an 18-bit accumulator and returns to ARMED (valid stays 0) until 4 measurements complete; the 4th -> DONE with result = accumulator>>2 (truncating), valid=1; meas_cnt increments per DONE, not per sub-measurement.
REQ-025 With MICRO_TDC_AVG_EN: any sub-measurement saturation -> immediate DONE, result=0xFFFF, ovf=1; abort and arm-in-DONE clear the accumulator and sub-count.

Verification
REQ-026 Reset, select each of 00..11 -> uo_out=0x00 in every case; status byte 0x00.
REQ-027 Arm, start at edge k, stop at edge k+37 -> status state=3, valid=1, ovf=0, meas_cnt=1; select 00 -> 0x25, 01 -> 0x00.
REQ-028 Arm, start, stop held low 65,540 cycles -> result 0xFFFF, ovf=1, status byte 0xF1.
REQ-029 Arm, start and stop rising in same cycle -> result 0x0000, valid=1; stop-before-start in ARMED -> ignored, state stays 1.
REQ-030 Arm, start, abort after 10 cycles -> status 0x00, result 0x0000; then rst_n pulsed low mid-RUN -> status 0x00.
REQ-031 With MICRO_TDC_AVG_EN: four arm-free start/stop pairs of 10, 11, 12, 14 cycles -> result 0x000B, valid=1, meas_cnt=1.
